// File: rtl/ita_mask_gen.sv
// Attention-mask generator for the QK step: tracks row/column from a beat counter and emits one N-lane mask per beat.
// Optional sequence-length padding is enabled by defining ITA_MASK_PADDING_EN (adds port seq_len_i).
module ita_mask_gen #(
  parameter int N  = 16,
  parameter int M  = 64,
  parameter int CW = 16,
  parameter int SW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [2:0]    mode_i,
  input  logic [CW-1:0] offset_i,
  input  logic [SW-1:0] stride_i,
  input  logic [SW-1:0] window_i,
  input  logic          tile_start_i,
  input  logic [CW-1:0] tile_x_i,
  input  logic [CW-1:0] tile_y_i,
`ifdef ITA_MASK_PADDING_EN
  input  logic [CW-1:0] seq_len_i,
`endif
  input  logic          en_i,
  input  logic          last_inner_i,
  output logic          ready_o,
  output logic [N-1:0]  mask_o,
  output logic          mask_valid_o
);

  localparam int LOGM  = $clog2(M);
  localparam int LOGN  = $clog2(N);
  localparam int BEATS = M * M / N;
  localparam int BW    = $clog2(BEATS);
  localparam int PW    = $clog2(CW + 1);
  localparam logic [CW-1:0] STEP_C  = CW'(M - 1 + N);
  localparam logic [BW-1:0] LAST_B  = BW'(BEATS - 1);
  localparam logic [PW-1:0] PREP_END = PW'(CW);

  typedef enum logic [1:0] {IDLE, PREP, RUN} state_t;
  typedef enum logic [2:0] {
    M_NONE, M_UPPER, M_LOWER, M_STRIDED, M_UPPER_STR, M_LOWER_STR, M_WINDOW, M_STR_WINDOW
  } mode_t;

  state_t state, state_next;

  mode_t         mode_q;
  logic [CW-1:0] offset_q;
  logic [SW-1:0] stride_q;
  logic [SW-1:0] window_q;
  logic [CW-1:0] tile_x_q;
  logic [CW-1:0] tile_y_q;
`ifdef ITA_MASK_PADDING_EN
  logic [CW-1:0] seq_len_q;
  logic [CW-1:0] col0;
`endif

  logic [PW-1:0] prep_cnt;
  logic [CW-1:0] d_base;
  logic [SW-1:0] r_base;
  logic [SW-1:0] k_q;
  logic          neg_q;
  logic [CW-1:0] div_a, div_b;
  logic [SW-1:0] rem_a, rem_b;

  logic [BW-1:0] beat;
  logic [CW-1:0] d0;
  logic [SW-1:0] r0;
  logic [N-1:0]  lane_mask;

  logic [CW-1:0] tile_diff, d_base_calc, d_mag;
  logic [SW-1:0] rem_a_nxt, rem_b_nxt, r_base_fin;
  logic [SW:0]   r_sum, r_wrap;
  logic          accept;

  function automatic logic [SW-1:0] rem_step(input logic [SW-1:0] rem, input logic bit_in,
                                             input logic [SW-1:0] s);
    logic [SW:0] t;
    t = {rem, bit_in};
    if (t >= {1'b0, s}) t = t - {1'b0, s};
    return t[SW-1:0];
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready_o    = 1'b0;
    if (tile_start_i) begin
      state_next = PREP;
    end else begin
      case (state)
        IDLE: state_next = IDLE;
        PREP: if (prep_cnt == PREP_END) state_next = RUN;
        RUN:  state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
    if (state == RUN) ready_o = 1'b1;
  end

  assign accept = (state == RUN) && en_i && !tile_start_i;

  // Diagonal distance of the tile's first lane, and its magnitude for the remainder units.
  assign tile_diff   = tile_x_q - tile_y_q;
  assign d_base_calc = (tile_diff << LOGM) + offset_q;
  assign d_mag       = d_base_calc[CW-1] ? (~d_base_calc + 1'b1) : d_base_calc;

  assign rem_a_nxt  = rem_step(rem_a, div_a[CW-1], stride_q);
  assign rem_b_nxt  = rem_step(rem_b, div_b[CW-1], stride_q);
  assign r_base_fin = (neg_q && rem_a_nxt != '0) ? (stride_q - rem_a_nxt) : rem_a_nxt;

  assign r_sum  = {1'b0, r0} + {1'b0, k_q};
  assign r_wrap = (r_sum >= {1'b0, stride_q}) ? (r_sum - {1'b0, stride_q}) : r_sum;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q   <= M_NONE;
      offset_q <= '0;
      stride_q <= '0;
      window_q <= '0;
      tile_x_q <= '0;
      tile_y_q <= '0;
`ifdef ITA_MASK_PADDING_EN
      seq_len_q <= '0;
`endif
      prep_cnt <= '0;
      d_base   <= '0;
      r_base   <= '0;
      k_q      <= '0;
      neg_q    <= 1'b0;
      div_a    <= '0;
      div_b    <= '0;
      rem_a    <= '0;
      rem_b    <= '0;
      beat     <= '0;
      d0       <= '0;
      r0       <= '0;
    end else if (tile_start_i) begin
      mode_q   <= mode_t'(mode_i);
      offset_q <= offset_i;
      stride_q <= (stride_i == '0) ? SW'(1) : stride_i;
      window_q <= window_i;
      tile_x_q <= tile_x_i;
      tile_y_q <= tile_y_i;
`ifdef ITA_MASK_PADDING_EN
      seq_len_q <= seq_len_i;
`endif
      prep_cnt <= '0;
      beat     <= '0;
    end else begin
      case (state)
        PREP: begin
          if (prep_cnt == '0) begin
            d_base <= d_base_calc;
            neg_q  <= d_base_calc[CW-1];
            div_a  <= d_mag;
            div_b  <= STEP_C;
            rem_a  <= '0;
            rem_b  <= '0;
          end else begin
            div_a <= div_a << 1;
            div_b <= div_b << 1;
            rem_a <= rem_a_nxt;
            rem_b <= rem_b_nxt;
          end
          // Last division step lands here; the sign fix-up is folded into the hand-off to RUN.
          if (prep_cnt == PREP_END) begin
            prep_cnt <= '0;
            r_base   <= r_base_fin;
            k_q      <= rem_b_nxt;
            d0       <= d_base;
            r0       <= r_base_fin;
            beat     <= '0;
          end else begin
            prep_cnt <= prep_cnt + 1'b1;
          end
        end
        RUN: begin
          if (en_i) begin
            if (beat == LAST_B) begin
              beat <= '0;
              d0   <= d_base;
              r0   <= r_base;
            end else begin
              beat <= beat + 1'b1;
              if (&beat[LOGM-1:0]) begin
                d0 <= d0 + STEP_C;
                r0 <= r_wrap[SW-1:0];
              end else begin
                d0 <= d0 - 1'b1;
                r0 <= (r0 == '0) ? (stride_q - 1'b1) : (r0 - 1'b1);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ITA_MASK_PADDING_EN
  assign col0 = (tile_x_q << LOGM) + ((CW'(beat) >> LOGM) << LOGN);
`endif

  always_comb begin : lane_logic
    logic [SW:0]          r;
    logic signed [CW-1:0] d;
    logic signed [CW-1:0] neg_w;
    logic                 upper, lower, outside, res, b;
    lane_mask = '0;
    r         = {1'b0, r0};
    neg_w     = -$signed(CW'(window_q));
    for (int i = 0; i < N; i++) begin
      if (i > 0) r = ((r + 1'b1) == {1'b0, stride_q}) ? '0 : (r + 1'b1);
      d       = $signed(d0 + CW'(i));
      upper   = d > 0;
      lower   = d < 0;
      outside = upper || (d < neg_w);
      res     = (r != '0);
      case (mode_q)
        M_UPPER:      b = upper;
        M_LOWER:      b = lower;
        M_STRIDED:    b = res;
        M_UPPER_STR:  b = upper | res;
        M_LOWER_STR:  b = lower | res;
        M_WINDOW:     b = outside;
        M_STR_WINDOW: b = outside | res;
        default:      b = 1'b0;
      endcase
`ifdef ITA_MASK_PADDING_EN
      if ((col0 + CW'(i)) >= seq_len_q) b = 1'b1;
`endif
      lane_mask[i] = b;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mask_o       <= '0;
      mask_valid_o <= 1'b0;
    end else begin
      mask_o       <= (accept && last_inner_i) ? lane_mask : '0;
      mask_valid_o <= accept;
    end
  end

endmodule

// File: tb/tb_ita_mask_gen.sv
// Scoreboard bench for ita_mask_gen: expected masks come from a direct col/row model, not the beat recurrence.
module tb_ita_mask_gen;
  localparam int N = 16, M = 64, CW = 16, SW = 8, BEATS = M * M / N;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [2:0]    mode_i;
  logic [CW-1:0] offset_i;
  logic [SW-1:0] stride_i;
  logic [SW-1:0] window_i;
  logic          tile_start_i;
  logic [CW-1:0] tile_x_i;
  logic [CW-1:0] tile_y_i;
`ifdef ITA_MASK_PADDING_EN
  logic [CW-1:0] seq_len_i;
`endif
  logic          en_i;
  logic          last_inner_i;
  logic          ready_o;
  logic [N-1:0]  mask_o;
  logic          mask_valid_o;

  int tests = 0;
  int fails = 0;
  logic [N-1:0] sb[$];
  int cfg_mode, cfg_off, cfg_s, cfg_w, cfg_tx, cfg_ty;
  int cfg_seq = 65535;
  int tb_beat = 0;
  bit tb_running = 0;
  logic [N-1:0] or_acc;

  always #5 clk_i = ~clk_i;

  ita_mask_gen #(.N(N), .M(M), .CW(CW), .SW(SW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .mode_i(mode_i), .offset_i(offset_i),
    .stride_i(stride_i), .window_i(window_i), .tile_start_i(tile_start_i),
    .tile_x_i(tile_x_i), .tile_y_i(tile_y_i),
`ifdef ITA_MASK_PADDING_EN
    .seq_len_i(seq_len_i),
`endif
    .en_i(en_i), .last_inner_i(last_inner_i), .ready_o(ready_o),
    .mask_o(mask_o), .mask_valid_o(mask_valid_o)
  );

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h (beat %0d)", tag, got, exp, tb_beat);
    end
  endtask

  function automatic logic [N-1:0] model_mask(input int b);
    int row, col, d, r;
    bit up, lo, win, st, bv;
    logic [N-1:0] m;
    m   = '0;
    row = cfg_ty * M + b % M;
    for (int i = 0; i < N; i++) begin
      col = cfg_tx * M + (b / M) * N + i;
      d   = col - row + cfg_off;
      r   = d % cfg_s;
      if (r < 0) r += cfg_s;
      up  = d > 0;
      lo  = d < 0;
      win = up || (d < -cfg_w);
      st  = r != 0;
      case (cfg_mode)
        1: bv = up;
        2: bv = lo;
        3: bv = st;
        4: bv = up | st;
        5: bv = lo | st;
        6: bv = win;
        7: bv = win | st;
        default: bv = 1'b0;
      endcase
`ifdef ITA_MASK_PADDING_EN
      if (col >= cfg_seq) bv = 1'b1;
`endif
      m[i] = bv;
    end
    return m;
  endfunction

  // One clock: drive a beat, predict it, then compare what the DUT registered.
  task automatic applyStimulus(input logic en, input logic li);
    logic exp_valid;
    en_i         = en;
    last_inner_i = li;
    exp_valid    = en && tb_running;
    if (exp_valid) begin
      sb.push_back(li ? model_mask(tb_beat) : '0);
      tb_beat = (tb_beat + 1) % BEATS;
    end
    @(posedge clk_i); #1;
    en_i = 1'b0;
    checkOutput("valid", 32'(mask_valid_o), 32'(exp_valid));
    if (exp_valid && sb.size() > 0) checkOutput("mask", 32'(mask_o), 32'(sb.pop_front()));
    else checkOutput("mask_idle", 32'(mask_o), 32'h0);
  endtask

  task automatic run_beats(input int n, input logic li);
    for (int k = 0; k < n; k++) applyStimulus(1'b1, li);
  endtask

  task automatic start_tile(input int mode, input int off, input int s, input int w,
                            input int tx, input int ty, input logic en_same);
    int cnt;
    cfg_mode = mode; cfg_off = off; cfg_s = (s == 0) ? 1 : s; cfg_w = w;
    cfg_tx = tx; cfg_ty = ty;
    mode_i   = 3'(mode);
    offset_i = CW'(off);
    stride_i = SW'(s);
    window_i = SW'(w);
    tile_x_i = CW'(tx);
    tile_y_i = CW'(ty);
`ifdef ITA_MASK_PADDING_EN
    seq_len_i = CW'(cfg_seq);
`endif
    tile_start_i = 1'b1;
    en_i         = en_same;
    last_inner_i = 1'b1;
    @(posedge clk_i); #1;
    tile_start_i = 1'b0;
    en_i         = 1'b0;
    tb_running   = 0;
    tb_beat      = 0;
    checkOutput("start_valid", 32'(mask_valid_o), 32'h0);
    mode_i   = 3'($urandom);
    offset_i = CW'($urandom);
    stride_i = SW'($urandom);
    window_i = SW'($urandom);
    tile_x_i = CW'($urandom);
    tile_y_i = CW'($urandom);
`ifdef ITA_MASK_PADDING_EN
    seq_len_i = CW'($urandom);
`endif
    cnt = 0;
    while (ready_o !== 1'b1 && cnt < 100) begin
      cnt++;
      @(posedge clk_i); #1;
    end
    checkOutput("prep_len", 32'(cnt), 32'(CW + 1));
    tb_running = 1;
  endtask

  initial begin
    rst_ni = 1'b0;
    mode_i = '0; offset_i = '0; stride_i = '0; window_i = '0;
    tile_start_i = 1'b0; tile_x_i = '0; tile_y_i = '0;
`ifdef ITA_MASK_PADDING_EN
    seq_len_i = '0;
`endif
    en_i = 1'b0; last_inner_i = 1'b0;
    #12;
    checkOutput("rst_ready", 32'(ready_o), 32'h0);
    checkOutput("rst_mask", 32'(mask_o), 32'h0);
    checkOutput("rst_valid", 32'(mask_valid_o), 32'h0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    applyStimulus(1'b1, 1'b1);

    start_tile(1, 0, 1, 0, 0, 0, 1'b0);
    run_beats(1, 1'b1);
    checkOutput("upper_b0", 32'(mask_o), 32'hFFFE);
    run_beats(5, 1'b1);
    checkOutput("upper_b5", 32'(mask_o), 32'hFFC0);
    applyStimulus(1'b0, 1'b1);

    start_tile(3, 0, 3, 0, 0, 0, 1'b0);
    run_beats(1, 1'b1);
    checkOutput("strided_b0", 32'(mask_o), 32'h6DB6);
    run_beats(64, 1'b1);
    checkOutput("strided_b64", 32'(mask_o), 32'hB6DB);

    start_tile(6, 0, 1, 2, 0, 0, 1'b0);
    run_beats(5, 1'b1);
    checkOutput("window_b4", 32'(mask_o), 32'hFFE3);

    start_tile(1, 0, 1, 0, 0, 1, 1'b0);
    or_acc = '0;
    for (int k = 0; k < BEATS; k++) begin
      applyStimulus(1'b1, 1'b1);
      or_acc |= mask_o;
    end
    checkOutput("upper_y1_all", 32'(or_acc), 32'h0);

    start_tile(7, 5, 5, 7, 2, 1, 1'b0);
    run_beats(BEATS + 1, 1'b1);
    checkOutput("wrap_b256", 32'(mask_o), 32'(model_mask(0)));

    start_tile(5, -20, 4, 0, 1, 0, 1'b0);
    for (int k = 0; k < 30; k++) applyStimulus(1'b1, 1'(k % 2));
    start_tile(4, 13, 0, 0, 0, 2, 1'b1);
    for (int k = 0; k < 70; k++) applyStimulus(1'(k % 3 != 0), 1'b1);

    start_tile(2, -70, 7, 0, 3, 2, 1'b0);
    run_beats(80, 1'b1);

    for (int t = 0; t < 4; t++) begin
      start_tile(int'($urandom_range(0, 7)), int'($urandom_range(0, 200)) - 100,
                 int'($urandom_range(0, 9)), int'($urandom_range(0, 20)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
      for (int k = 0; k < 80; k++)
        applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
    end

`ifdef ITA_MASK_PADDING_EN
    cfg_seq = 10;
    start_tile(0, 0, 1, 0, 0, 0, 1'b0);
    run_beats(1, 1'b1);
    checkOutput("pad_none_b0", 32'(mask_o), 32'hFC00);
    cfg_seq = 65535;
`endif

    start_tile(1, 0, 1, 0, 0, 0, 1'b0);
    run_beats(3, 1'b1);
    rst_ni = 1'b0;
    #1;
    checkOutput("midrst_ready", 32'(ready_o), 32'h0);
    checkOutput("midrst_mask", 32'(mask_o), 32'h0);
    checkOutput("midrst_valid", 32'(mask_valid_o), 32'h0);
    @(posedge clk_i); #1;
    checkOutput("midrst_idle", 32'(ready_o), 32'h0);
    rst_ni     = 1'b1;
    tb_running = 0;
    sb.delete();
    applyStimulus(1'b1, 1'b1);
    checkOutput("post_rst_ready", 32'(ready_o), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
